serdes_link_trainer: RTL

//  Sequences bring-up of the 8-bit LVDS receive deserializer (two IO-wizard groups: 24b grp0, 16b grp1).

---
 rtl/serdes_pkg.sv | 63 ++++++
 rtl/serdes_link_trainer_if.sv | 26 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/serdes_link_trainer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and constants for the SerDes receive link trainer.
package serdes_pkg;

    // FSM states; the encodings are visible on the state_dbg pins.
    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_RST_DES   = 3'd1,
        ST_TRAIN1    = 3'd2,
        ST_TRAIN0    = 3'd3,
        ST_UP        = 3'd4,
        ST_RETRY     = 3'd5,
        ST_FAIL      = 3'd6
    } state_e;

    // Pattern the far-end TX sends while tx_train_req is high.
    localparam logic [7:0] IDLE_PATTERN = 8'h7E;

    // Deserializer group indices into grp_aligned / serd_cmd.
    localparam int GRP0 = 0;
    localparam int GRP1 = 1;

    // Shared phase timer width; wide enough for the longest training window.
    localparam int TIMER_W = 16;

    // Registered control outputs, decoded from the FSM state.
    typedef struct packed {
        logic       deser_rst;
        logic [1:0] serd_cmd;
        logic       tx_train_req;
        logic       link_up;
        logic       link_fail;
    } out_s;

    // Output decode for a given state. RETRY holds the deserializer in reset
    // and keeps the far end training so the next attempt starts clean.
    function automatic out_s decode_outputs(input state_e st);
        out_s o;
        o = '{deser_rst: 1'b1, serd_cmd: 2'b00, tx_train_req: 1'b0,
              link_up: 1'b0, link_fail: 1'b0};
        case (st)
            ST_RST_DES: o.tx_train_req = 1'b1;
            ST_TRAIN1: begin
                o.deser_rst      = 1'b0;
                o.serd_cmd[GRP1] = 1'b1;
                o.tx_train_req   = 1'b1;
            end
            ST_TRAIN0: begin
                o.deser_rst      = 1'b0;
                o.serd_cmd[GRP0] = 1'b1;
                o.tx_train_req   = 1'b1;
            end
            ST_UP: begin
                o.deser_rst = 1'b0;
                o.link_up   = 1'b1;
            end
            ST_RETRY:   o.tx_train_req = 1'b1;
            ST_FAIL:    o.link_fail    = 1'b1;
            default:    o = o;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/serdes_link_trainer_if.sv
// Status/control bundle between the link trainer, the deserializer pins and
// the link control registers. slave = trainer side, master = environment side.
interface serdes_link_trainer_if;
    logic       io_locked;
    logic [1:0] grp_aligned;
    logic       retrain;
    logic       deser_rst;
    logic [1:0] serd_cmd;
    logic       tx_train_req;
    logic       link_up;
    logic       link_fail;
    logic [3:0] retry_cnt;
    logic [2:0] state_dbg;

    modport slave (
        input  io_locked, grp_aligned, retrain,
        output deser_rst, serd_cmd, tx_train_req, link_up, link_fail,
               retry_cnt, state_dbg
    );

    modport master (
        output io_locked, grp_aligned, retrain,
        input  deser_rst, serd_cmd, tx_train_req, link_up, link_fail,
               retry_cnt, state_dbg
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow level signal.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Double-register the asynchronous input; reset reads as "not locked".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/serdes_link_trainer.sv
// Bring-up sequencer for the two-group LVDS receive deserializer: waits for
// IO clock lock, pulses the deserializer reset, trains grp1 then grp0 via
// bitslip enables, and retries or fails on timeout / loss of alignment.
module serdes_link_trainer
    import serdes_pkg::*;
#(
    parameter int unsigned LOCK_WAIT     = 256,
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned TRAIN_TIMEOUT = 4096,
    parameter logic [3:0]  MAX_RETRY     = 4'd3
) (
    input  logic                  clk,
    input  logic                  reset,
    serdes_link_trainer_if.slave  link
);

    localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_WAIT - 1);
    localparam logic [TIMER_W-1:0] RST_LAST   = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TRAIN_LAST = TIMER_W'(TRAIN_TIMEOUT - 1);

    logic               w_lock;
    state_e             r_state;
    state_e             w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic [3:0]         r_retry_cnt;
    logic [3:0]         w_retry_next;
    out_s               r_out;
    out_s               w_out_next;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (link.io_locked),
        .o_q   (w_lock)
    );

    // Next-state, timer and retry-count logic; retrain beats lock loss,
    // which beats every phase transition (FAIL ignores lock loss).
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_retry_next = r_retry_cnt;

        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock && (r_timer == LOCK_LAST)) begin
                    w_state_next = ST_RST_DES;
                end
            end
            ST_RST_DES: begin
                if (r_timer == RST_LAST) begin
                    w_state_next = ST_TRAIN1;
                end
            end
            ST_TRAIN1: begin
                if (link.grp_aligned[GRP1]) begin
                    w_state_next = ST_TRAIN0;
                end else if (r_timer == TRAIN_LAST) begin
                    w_state_next = ST_RETRY;
                end
            end
            ST_TRAIN0: begin
                if (!link.grp_aligned[GRP1]) begin
                    w_state_next = ST_RETRY;
                end else if (link.grp_aligned[GRP0]) begin
                    w_state_next = ST_UP;
                end else if (r_timer == TRAIN_LAST) begin
                    w_state_next = ST_RETRY;
                end
            end
            ST_UP: begin
                if (link.grp_aligned != 2'b11) begin
                    w_state_next = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (r_retry_cnt == MAX_RETRY) begin
                    w_state_next = ST_FAIL;
                end else begin
                    w_state_next = ST_RST_DES;
                end
            end
            ST_FAIL:  w_state_next = ST_FAIL;
            default:  w_state_next = ST_WAIT_LOCK;
        endcase

        if (!w_lock && (r_state != ST_FAIL)) begin
            w_state_next = ST_WAIT_LOCK;
        end
        if (link.retrain) begin
            w_state_next = ST_WAIT_LOCK;
        end

        // Timer restarts on every state entry (a retrain counts as one),
        // is held at zero while waiting without lock, and saturates.
        if ((w_state_next != r_state) || link.retrain) begin
            w_timer_next = '0;
        end else if ((r_state == ST_WAIT_LOCK) && !w_lock) begin
            w_timer_next = '0;
        end else if (r_timer != '1) begin
            w_timer_next = r_timer + 1'b1;
        end

        // Attempts are counted on entry to RETRY so the count is already
        // updated while RETRY decides between another attempt and FAIL.
        if (link.retrain) begin
            w_retry_next = '0;
        end else if ((w_state_next == ST_RETRY) && (r_state != ST_RETRY)
                     && (r_retry_cnt != 4'hF)) begin
            w_retry_next = r_retry_cnt + 4'd1;
        end

        w_out_next = decode_outputs(w_state_next);
    end

    // State, timer and retry-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_WAIT_LOCK;
            r_timer     <= '0;
            r_retry_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_retry_cnt <= w_retry_next;
        end
    end

    // Output registers, loaded from the next-state decode so they switch
    // together with state_dbg.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= decode_outputs(ST_WAIT_LOCK);
        end else begin
            r_out <= w_out_next;
        end
    end

    assign link.deser_rst    = r_out.deser_rst;
    assign link.serd_cmd     = r_out.serd_cmd;
    assign link.tx_train_req = r_out.tx_train_req;
    assign link.link_up      = r_out.link_up;
    assign link.link_fail    = r_out.link_fail;
    assign link.retry_cnt    = r_retry_cnt;
    assign link.state_dbg    = r_state;

endmodule
